// File: rtl/alineador_pkg.sv
// Shared definitions for the receive-side symbol path: K28.5 patterns, symbol width,
// alignment state encoding and a saturating counter helper.
package alineador_pkg;

  localparam int SYM_W = 10;

  localparam logic [SYM_W-1:0] K28_5_RDN = 10'h17C;
  localparam logic [SYM_W-1:0] K28_5_RDP = 10'h283;

  localparam logic [3:0] BIT_LAST = 4'd9;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } estado_t;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/alineador_simbolos_detector_coma.sv
// Combinational K28.5 detector over a 10-bit window; reports which running
// disparity form was seen.
module detector_coma
  import alineador_pkg::*;
(
  input  logic [SYM_W-1:0] win,
  output logic             match,
  output logic             rdPlus
);

  logic w_rdn;
  logic w_rdp;

  assign w_rdn  = (win == K28_5_RDN);
  assign w_rdp  = (win == K28_5_RDP);
  assign match  = w_rdn | w_rdp;
  assign rdPlus = w_rdp;

endmodule

// File: rtl/alineador_simbolos.sv
// Serial-to-symbol aligner: hunts for K28.5 commas, confirms symbol lock and
// emits aligned 10-bit symbols with a valid strobe.
module alineador_simbolos
  import alineador_pkg::*;
#(
  parameter int LOCK_CNT = 3,
  parameter int LOSS_CNT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enb,
  input  logic             serialIn,
  output logic [SYM_W-1:0] symOut,
  output logic             symValid,
  output logic             isComma,
  output logic             locked,
  output logic             alignErr
);

  localparam logic [3:0] LOCK_N = 4'(LOCK_CNT);
  localparam logic [3:0] LOSS_N = 4'(LOSS_CNT);

  estado_t          r_state;
  logic [SYM_W-1:0] r_sr;
  logic [3:0]       r_bit_cnt;
  logic [3:0]       r_conf_cnt;
  logic [3:0]       r_err_cnt;
  logic [SYM_W-1:0] r_sym_out;
  logic             r_sym_valid;
  logic             r_is_comma;
  logic             r_locked;
  logic             r_align_err;

  logic [SYM_W-1:0] w_win;
  logic             w_match;
  logic             w_rd_plus;
  logic             w_comma;
  logic             w_boundary;
  logic [3:0]       w_conf_inc;
  logic [3:0]       w_err_inc;

  // The window includes the bit being sampled now, so a comma is recognised on
  // the same edge that shifts in its last bit.
  assign w_win = {serialIn, r_sr[SYM_W-1:1]};

  detector_coma u_detector (
    .win    (w_win),
    .match  (w_match),
    .rdPlus (w_rd_plus)
  );

  // rdPlus implies match; both forms of K28.5 qualify as a comma here.
  assign w_comma    = w_match | w_rd_plus;
  assign w_boundary = (r_bit_cnt == BIT_LAST);
  assign w_conf_inc = sat_inc(r_conf_cnt);
  assign w_err_inc  = sat_inc(r_err_cnt);

  // NOTE: every register in this block uses <= so all updates see the pre-edge
  // values; later assignments in the same branch override the defaults above them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= HUNT;
      r_sr        <= '0;
      r_bit_cnt   <= '0;
      r_conf_cnt  <= '0;
      r_err_cnt   <= '0;
      r_sym_out   <= '0;
      r_sym_valid <= 1'b0;
      r_is_comma  <= 1'b0;
      r_locked    <= 1'b0;
      r_align_err <= 1'b0;
    end else if (enb) begin
      r_sr        <= w_win;
      r_sym_valid <= 1'b0;
      r_align_err <= 1'b0;
      r_bit_cnt   <= w_boundary ? 4'd0 : r_bit_cnt + 4'd1;

      case (r_state)
        HUNT: begin
          if (w_comma) begin
            r_bit_cnt  <= 4'd0;
            r_conf_cnt <= 4'd1;
            r_err_cnt  <= 4'd0;
            if (LOCK_N == 4'd1) begin
              r_state  <= LOCKED;
              r_locked <= 1'b1;
            end else begin
              r_state <= SYNC;
            end
          end
        end

        SYNC: begin
          if (w_comma && w_boundary) begin
            r_conf_cnt <= w_conf_inc;
            if (w_conf_inc >= LOCK_N) begin
              r_state     <= LOCKED;
              r_locked    <= 1'b1;
              r_err_cnt   <= 4'd0;
              r_sym_out   <= w_win;
              r_sym_valid <= 1'b1;
              r_is_comma  <= 1'b1;
            end
          end else if (w_comma) begin
            r_align_err <= 1'b1;
            r_bit_cnt   <= 4'd0;
            r_conf_cnt  <= 4'd1;
          end
        end

        LOCKED: begin
          if (w_boundary) begin
            r_sym_out   <= w_win;
            r_sym_valid <= 1'b1;
            r_is_comma  <= w_comma;
            if (w_comma) r_err_cnt <= 4'd0;
          end else if (w_comma) begin
            // Symbol timing is kept while locked; only repeated slips drop lock.
            r_align_err <= 1'b1;
            if (w_err_inc >= LOSS_N) begin
              r_state    <= HUNT;
              r_locked   <= 1'b0;
              r_err_cnt  <= 4'd0;
              r_conf_cnt <= 4'd0;
            end else begin
              r_err_cnt <= w_err_inc;
            end
          end
        end

        default: begin
          r_state  <= HUNT;
          r_locked <= 1'b0;
        end
      endcase
    end else begin
      r_sym_valid <= 1'b0;
      r_align_err <= 1'b0;
    end
  end

  assign symOut   = r_sym_out;
  assign symValid = r_sym_valid;
  assign isComma  = r_is_comma;
  assign locked   = r_locked;
  assign alignErr = r_align_err;

endmodule
